// File: rtl/audiouart_pio_pkg.sv
// rtl/audiouart_pio_pkg.sv - register map and edge-type constants for the audio UART PIO ports
package audiouart_pio_pkg;

    localparam int PIO_DATA_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/audiouart_debounce.sv
// rtl/audiouart_debounce.sv - single-bit 2-flop synchroniser, optional debounce, level register
// The debounce counter is built only when AUDIOUART_KEY_DEBOUNCE_EN is defined.
module audiouart_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_armed,
    input  logic i_in,
    output logic o_sync,
    output logic o_level
);

    logic r_sync1;
    logic r_sync2;
    logic r_level;
    logic w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
            // Before arming, track the input directly so idle levels settle without a capture.
            if (!i_armed || w_accept)
                r_level <= r_sync2;
        end
    end

`ifdef AUDIOUART_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign w_accept = (r_sync2 != r_level) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!i_armed || (r_sync2 == r_level) || w_accept)
            r_cnt <= '0;
        else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_accept = 1'b1;
`endif

    assign o_sync  = r_sync2;
    assign o_level = r_level;

endmodule

// File: rtl/audiouart_key_pio.sv
// rtl/audiouart_key_pio.sv - Avalon-MM key/switch input port with edge capture and maskable irq
// Optional debouncing is enabled by defining AUDIOUART_KEY_DEBOUNCE_EN.
module audiouart_key_pio
    import audiouart_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [WIDTH-1:0]      in_port,
    output logic [PIO_DATA_W-1:0] readdata,
    output logic                  irq
);

    logic [1:0]       r_arm;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edges;
    logic [WIDTH-1:0] w_clr;
    logic             w_armed;
    logic             w_wr;

    assign w_armed = (r_arm == 2'd3);
    assign w_wr    = chipselect && !write_n;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        audiouart_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .i_armed (w_armed),
            .i_in    (in_port[g]),
            .o_sync  (w_sync[g]),
            .o_level (w_level[g])
        );
    end

    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;

    always_comb begin
        w_edges = '0;
        if (w_armed) begin
            case (EDGE_TYPE)
                EDGE_RISE: w_edges = w_rise;
                EDGE_FALL: w_edges = w_fall;
                default:   w_edges = w_rise | w_fall;
            endcase
        end
    end

    assign w_clr = (w_wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm     <= 2'd0;
            r_level_d <= '0;
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (!w_armed)
                r_arm <= r_arm + 2'd1;
            r_level_d <= w_armed ? w_level : w_sync;
            if (w_wr && address == PIO_ADDR_IRQMASK)
                r_irqmask <= writedata[WIDTH-1:0];
            // A fresh edge overrides a simultaneous write-1-to-clear.
            r_edgecap <= (r_edgecap & ~w_clr) | w_edges;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                PIO_ADDR_DATA:    readdata[WIDTH-1:0] = w_level;
                PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
                PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
                default:          readdata = '0;
            endcase
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_audiouart_key_pio.sv
// tb/tb_audiouart_key_pio.sv - directed self-checking bench for audiouart_key_pio
module tb_audiouart_key_pio;

    localparam int LVL_LAT =
`ifdef AUDIOUART_KEY_DEBOUNCE_EN
        18;
`else
        3;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audiouart_key_pio #(
        .WIDTH(4),
        .EDGE_TYPE(1),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0;
        step(3);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_in_reset: got %b want 0", irq); end
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data_in_reset: got %h want 0", d); end
        reset_n = 1'b1;
        step(10);
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0000000F) begin n_fail++; $display("FAIL reset_data: got %h want 0000000f", d); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_edgecap: got %h want 0", d); end
        rd(2'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_irqmask: got %h want 0", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_edge_capture;
        logic [31:0] d;
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        step(LVL_LAT - 1);
        rd(2'd0, d);
        n_checks++; if (d !== 32'hF) begin n_fail++; $display("FAIL edge_data_early: got %h want f", d); end
        step(1);
        rd(2'd0, d);
        n_checks++; if (d !== 32'hE) begin n_fail++; $display("FAIL edge_data: got %h want e", d); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_cap_early: got %h want 0", d); end
        step(1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL edge_cap: got %h want 1", d); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq: got %b want 1", irq); end
    endtask

    task automatic test_w1c;
        logic [31:0] d;
        wr(2'd3, 32'h0);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_zero_keeps: got %h want 1", d); end
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b want 0", irq); end
        step(1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_stays: got %h want 0", d); end
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        in_port = 4'hC;
        step(LVL_LAT + 1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL bit1_fall_cap: got %h want 2", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL bit1_masked_irq: got %b want 0", irq); end
        wr(2'd3, 32'h2);
        in_port = 4'hE;
        step(LVL_LAT + 2);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rise_ignored: got %h want 0", d); end
        in_port = 4'hC;
        step(LVL_LAT);
        wr(2'd3, 32'h2);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins: got %h want 2", d); end
        wr(2'd3, 32'h2);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL set_wins_cleanup: got %h want 0", d); end
    endtask

    task automatic test_reg_access;
        logic [31:0] d;
        wr(2'd0, 32'hFFFFFFFF);
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd0, d);
        n_checks++; if (d !== 32'hC) begin n_fail++; $display("FAIL data_ro: got %h want c", d); end
        rd(2'd1, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_read: got %h want 0", d); end
        rd(2'd2, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL mask_untouched: got %h want 1", d); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cap_untouched: got %h want 0", d); end
        wr(2'd2, 32'hFFFFFFFF);
        rd(2'd2, d);
        n_checks++; if (d !== 32'h0000000F) begin n_fail++; $display("FAIL mask_width: got %h want 0000000f", d); end
    endtask

    task automatic test_mask_gating;
        logic [31:0] d;
        wr(2'd2, 32'h0);
        in_port = 4'h4;
        step(LVL_LAT + 1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL bit3_cap: got %h want 8", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_off_irq: got %b want 0", irq); end
        wr(2'd2, 32'h8);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_on_irq: got %b want 1", irq); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        reset_n = 1'b0;
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b want 0", irq); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_cap: got %h want 0", d); end
        rd(2'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_mask: got %h want 0", d); end
        step(2);
        reset_n = 1'b1;
        step(10);
        rd(2'd0, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL rearm_data: got %h want 4", d); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rearm_cap: got %h want 0", d); end
    endtask

`ifdef AUDIOUART_KEY_DEBOUNCE_EN
    task automatic test_glitch;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            in_port = 4'h0;
            step(10);
            in_port = 4'h4;
            step(10);
        end
        rd(2'd0, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL glitch_data: got %h want 4", d); end
        rd(2'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_cap: got %h want 0", d); end
        in_port = 4'h0;
        step(LVL_LAT - 1);
        rd(2'd0, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL hold_data_early: got %h want 4", d); end
        step(1);
        rd(2'd0, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL hold_data: got %h want 0", d); end
        step(1);
        rd(2'd3, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL hold_cap: got %h want 4", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_edge_capture();
        test_w1c();
        test_set_wins();
        test_reg_access();
        test_mask_gating();
        test_reset_mid();
`ifdef AUDIOUART_KEY_DEBOUNCE_EN
        test_glitch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
